// File: rtl/ifetch_stage_if.sv
// IF-stage bus: hazard/redirect inputs, program-load port and the registered IF/ID outputs.
// master = fetch stage (drives IF/ID), slave = control/decode side.
interface ifetch_stage_if #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int IMEM_IDX_BITS = 8
);
  logic                     stall;
  logic                     flush;
  logic                     branch_taken;
  logic [ADDR_BITS-1:0]     branch_target;
  logic                     jump;
  logic [ADDR_BITS-1:0]     jump_target;
  logic                     prog_we;
  logic [IMEM_IDX_BITS-1:0] prog_addr;
  logic [DATA_WIDTH-1:0]    prog_data;
  logic                     step;
  logic [DATA_WIDTH-1:0]    inst_out;
  logic [ADDR_BITS-1:0]     next_pc_out;
  logic [ADDR_BITS-1:0]     pc_out;
  logic                     halted;

  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target,
           prog_we, prog_addr, prog_data, step,
    output inst_out, next_pc_out, pc_out, halted
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target,
           prog_we, prog_addr, prog_data, step,
    input  inst_out, next_pc_out, pc_out, halted
  );
endinterface

// File: rtl/ifetch_stage.sv
// MIPS instruction-fetch stage: PC, instruction memory with load port, IF/ID register, halt detect.
// Optional IFETCH_STEP_EN: non-redirect advances only on edges with step=1.
//
// state  | meaning
// S_RUN  | fetching normally (subject to stall/flush/step)
// S_HALT | HALT_WORD seen; PC and IF/ID frozen except by redirect, until reset
module ifetch_stage #(
  parameter int                        ADDR_BITS     = 32,
  parameter int                        DATA_WIDTH    = 32,
  parameter int                        IMEM_DEPTH    = 256,
  parameter int                        IMEM_IDX_BITS = 8,
  parameter logic [DATA_WIDTH-1:0]     HALT_WORD     = 32'hFFFF_FFFF
) (
  input  logic           clk,
  input  logic           rst_n,
  ifetch_stage_if.master bus
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t                   state_q;
  logic [ADDR_BITS-1:0]     pc_q;
  logic [DATA_WIDTH-1:0]    inst_q;
  logic [ADDR_BITS-1:0]     next_pc_q;
  logic [DATA_WIDTH-1:0]    imem_q [IMEM_DEPTH];

  logic [IMEM_IDX_BITS-1:0] fetch_idx;
  logic [DATA_WIDTH-1:0]    fetch_word;
  logic [ADDR_BITS-1:0]     pc_plus4;
  logic                     redirect;
  logic [ADDR_BITS-1:0]     redirect_tgt;
  logic                     advance;

  assign fetch_idx    = pc_q[IMEM_IDX_BITS+1:2];
  assign fetch_word   = imem_q[fetch_idx];
  assign pc_plus4     = pc_q + ADDR_BITS'(4);
  assign redirect     = bus.branch_taken | bus.jump;
  // The branch belongs to the older instruction, so it wins over a jump in ID.
  assign redirect_tgt = bus.branch_taken ? bus.branch_target : bus.jump_target;

`ifdef IFETCH_STEP_EN
  assign advance = bus.step;
`else
  logic step_unused;
  assign step_unused = bus.step;
  assign advance     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      imem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      pc_q      <= '0;
      inst_q    <= '0;
      next_pc_q <= '0;
    end else if (redirect) begin
      pc_q      <= redirect_tgt;
      inst_q    <= '0;
      next_pc_q <= '0;
    end else if (state_q == S_HALT || bus.stall || !advance) begin
      pc_q      <= pc_q;
      inst_q    <= inst_q;
      next_pc_q <= next_pc_q;
    end else if (bus.flush) begin
      pc_q      <= pc_plus4;
      inst_q    <= '0;
      next_pc_q <= '0;
    end else if (fetch_word == HALT_WORD) begin
      state_q   <= S_HALT;
      inst_q    <= '0;
      next_pc_q <= '0;
    end else begin
      pc_q      <= pc_plus4;
      inst_q    <= fetch_word;
      next_pc_q <= pc_plus4;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.inst_out    = inst_q;
  assign bus.next_pc_out = next_pc_q;
  assign bus.halted      = (state_q == S_HALT);

endmodule
